display_value_reg: RTL and testbench

- Memory-mapped output register between the RISC-V core's data-memory store path and the six-digit seven-segment display controller.
- Latches a 32-bit store and drives a registered 24-bit `data_to_display` word (6 nibbles, HEX5 = bits [23:20], HEX0 = bits [3:0]).
- Two modes: raw hex, or decimal via a sequential double-dabble binary-to-BCD converter.
- `data_to_display` is always a clean, fully defined register value, never X.

---
 rtl/display_pkg.sv | 38 +++
 rtl/bcd_dabble_step.sv | 30 +++
 rtl/display_value_reg.sv | 163 ++++++++++++++++
 tb/tb_display_value_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM state type and helper functions for the display value register.
// Used by display_value_reg and bcd_dabble_step.
package display_pkg;

   localparam logic [31:0] DATA_OFS      = 32'h0000_0000;
   localparam logic [31:0] CTRL_OFS      = 32'h0000_0004;
   localparam logic [19:0] DEC_MAX       = 20'd999999;
   localparam int unsigned CONV_BITS_DEF = 20;
   localparam int unsigned BCD_W         = 24;
   localparam int unsigned CNT_W         = 5;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } conv_state_t;

   // Largest value six decimal digits can show; anything larger is clamped to it.
   function automatic logic [31:0] saturate_dec(input logic [31:0] value);
      logic [31:0] sat;
      if (value > {12'h000, DEC_MAX}) begin
         sat = {12'h000, DEC_MAX};
      end else begin
         sat = value;
      end
      return sat;
   endfunction

   function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
      logic [3:0] res;
      if (digit >= 4'd5) begin
         res = digit + 4'd3;
      end else begin
         res = digit;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5,
// then shift {bcd, bin} left by one bit.
module bcd_dabble_step
   import display_pkg::*;
#(
   parameter int unsigned BIN_W = CONV_BITS_DEF
) (
   input  logic [BCD_W-1:0] bcd_in,
   input  logic [BIN_W-1:0] bin_in,
   output logic [BCD_W-1:0] bcd_out,
   output logic [BIN_W-1:0] bin_out
);

   logic [BCD_W-1:0] adj_s;
   logic             unused_msb_s;

   // Per-digit correction ahead of the shift.
   always_comb begin
      adj_s = {BCD_W{1'b0}};
      for (int i = 0; i < int'(BCD_W / 4); i++) begin
         adj_s[4*i +: 4] = add3_if_ge5(bcd_in[4*i +: 4]);
      end
   end

   // The top digit never exceeds 4 for in-range operands, so its MSB shifts out as zero.
   assign unused_msb_s = adj_s[BCD_W-1];
   assign bcd_out      = {adj_s[BCD_W-2:0], bin_in[BIN_W-1]};
   assign bin_out      = {bin_in[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/display_value_reg.sv
// Memory-mapped display value register with hex and sequential binary-to-BCD decimal modes.
// Optional readback mux enabled by defining DISPLAY_READBACK_EN.
module display_value_reg
   import display_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int unsigned CONV_BITS = CONV_BITS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              mode_dec,
   output logic [BCD_W-1:0]  data_to_display,
   output logic [31:0]       rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_BITS - 1);

   conv_state_t            state_r;
   conv_state_t            state_nxt_s;
   logic                   busy_r;
   logic                   mode_dec_r;
   logic [BCD_W-1:0]       disp_r;
   logic [BCD_W-1:0]       bcd_r;
   logic [CONV_BITS-1:0]   bin_r;
   logic [CNT_W-1:0]       cnt_r;

   logic                   data_wr_s;
   logic                   ctrl_wr_s;
   logic                   load_s;
   logic                   done_s;
   logic [CONV_BITS-1:0]   operand_s;
   logic [BCD_W-1:0]       step_bcd_s;
   logic [CONV_BITS-1:0]   step_bin_s;

   assign data_wr_s = we && (addr == (BASE_ADDR + DATA_OFS));
   assign ctrl_wr_s = we && (addr == (BASE_ADDR + CTRL_OFS));
   assign operand_s = CONV_BITS'(saturate_dec(wdata));

   bcd_dabble_step #(
      .BIN_W   (CONV_BITS)
   ) u_step (
      .bcd_in  (bcd_r),
      .bin_in  (bin_r),
      .bcd_out (step_bcd_s),
      .bin_out (step_bin_s)
   );

   // Next-state decode; a DATA write always takes priority over finishing a conversion.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (data_wr_s && mode_dec_r) begin
               state_nxt_s = CONVERT;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CONVERT: begin
            if (data_wr_s) begin
               if (mode_dec_r) begin
                  state_nxt_s = CONVERT;
                  load_s      = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = IDLE;
               done_s      = 1'b1;
            end else begin
               state_nxt_s = CONVERT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == CONVERT);
      end
   end

   // Mode bit; changing it never disturbs a running conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_dec_r <= 1'b0;
      end else if (ctrl_wr_s) begin
         mode_dec_r <= wdata[0];
      end else begin
         mode_dec_r <= mode_dec_r;
      end
   end

   // Converter datapath: load a fresh operand or advance one iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_r <= {CONV_BITS{1'b0}};
         bcd_r <= {BCD_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (load_s) begin
         bin_r <= operand_s;
         bcd_r <= {BCD_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == CONVERT) begin
         bin_r <= step_bin_s;
         bcd_r <= step_bcd_s;
         cnt_r <= cnt_r + 5'd1;
      end else begin
         bin_r <= bin_r;
         bcd_r <= bcd_r;
         cnt_r <= cnt_r;
      end
   end

   // Visible value: only whole hex words or finished BCD results are ever loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_r <= {BCD_W{1'b0}};
      end else if (data_wr_s && !mode_dec_r) begin
         disp_r <= wdata[BCD_W-1:0];
      end else if (done_s) begin
         disp_r <= step_bcd_s;
      end else begin
         disp_r <= disp_r;
      end
   end

   assign busy            = busy_r;
   assign mode_dec        = mode_dec_r;
   assign data_to_display = disp_r;

`ifdef DISPLAY_READBACK_EN
   // Combinational readback of the two registers.
   always_comb begin
      rdata = 32'h0000_0000;
      if (addr == (BASE_ADDR + DATA_OFS)) begin
         rdata = {8'h00, disp_r};
      end else if (addr == (BASE_ADDR + CTRL_OFS)) begin
         rdata = {30'h0000_0000, busy_r, mode_dec_r};
      end else begin
         rdata = 32'h0000_0000;
      end
   end
`else
   assign rdata = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_display_value_reg.sv
// Self-checking bench for display_value_reg: directed plus randomized steps against
// a decimal-digit reference model.
module tb_display_value_reg;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam logic [31:0] CTRL = 32'h0000_0404;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        mode_dec;
   logic [23:0] data_to_display;
   logic [31:0] rdata;

   int          tests_run;
   int          fails;
   logic [23:0] exp_disp;

   display_value_reg dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .we              (we),
      .addr            (addr),
      .wdata           (wdata),
      .busy            (busy),
      .mode_dec        (mode_dec),
      .data_to_display (data_to_display),
      .rdata           (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: saturate, then peel decimal digits with / and %.
   function automatic logic [23:0] to_bcd(input longint unsigned v);
      logic [23:0]     r;
      longint unsigned s;
      s = (v > 64'd999999) ? 64'd999999 : v;
      r = 24'h0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(s % 10);
         s = s / 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      we    = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;
   endtask

   task automatic hex_wr(input logic [31:0] d);
      @(negedge clk);
      chk("hex_pre", {8'h0, data_to_display}, {8'h0, exp_disp});
      we    = 1'b1;
      addr  = BASE;
      wdata = d;
      @(negedge clk);
      we    = 1'b0;
      addr  = 32'h0;
      exp_disp = d[23:0];
      chk("hex_1cyc", {8'h0, data_to_display}, {8'h0, exp_disp});
      chk("hex_busy", {31'h0, busy}, 32'h0);
   endtask

   // Decimal write: old value held and busy for 20 cycles, then the BCD result.
   task automatic dec_wr(input logic [31:0] v);
      wr(BASE, v);
      for (int k = 1; k <= 20; k++) begin
         chk("dec_hold", {8'h0, data_to_display}, {8'h0, exp_disp});
         chk("dec_busy", {31'h0, busy}, 32'h1);
         if (k < 20) @(negedge clk);
      end
      @(negedge clk);
      exp_disp = to_bcd(64'(v));
      chk("dec_result", {8'h0, data_to_display}, {8'h0, exp_disp});
      chk("dec_idle", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] r;
      tests_run = 0;
      fails     = 0;
      exp_disp  = 24'h0;
      rst_n = 1'b0;
      we    = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;

      repeat (3) @(negedge clk);
      chk("rst_disp", {8'h0, data_to_display}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_mode", {31'h0, mode_dec}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_disp", {8'h0, data_to_display}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);

      wr(CTRL, 32'h0);
      hex_wr(32'hFFAB_CDEF);

      wr(CTRL, 32'h1);
      chk("mode_set", {31'h0, mode_dec}, 32'h1);
      dec_wr(32'd123456);
      dec_wr(32'd1000000);
      dec_wr(32'd0);
      dec_wr(32'd999999);
      dec_wr(32'hFFFF_FFFF);

      for (int n = 0; n < 6; n++) begin
         r = 32'($urandom_range(0, 1200000));
         dec_wr(r);
      end
      wr(CTRL, 32'h0);
      for (int n = 0; n < 4; n++) begin
         r = $urandom;
         hex_wr(r);
      end

      // Overlap: restart with 7 on conversion cycle 10; 42 must never surface.
      wr(CTRL, 32'h1);
      wr(BASE, 32'd42);
      for (int k = 1; k < 10; k++) begin
         chk("ovl_hold", {8'h0, data_to_display}, {8'h0, exp_disp});
         @(negedge clk);
      end
      chk("ovl_busy", {31'h0, busy}, 32'h1);
      we    = 1'b1;
      addr  = BASE;
      wdata = 32'd7;
      @(negedge clk);
      we    = 1'b0;
      addr  = 32'h0;
      for (int k = 1; k <= 20; k++) begin
         chk("ovl_hold2", {8'h0, data_to_display}, {8'h0, exp_disp});
         if (k < 20) @(negedge clk);
      end
      @(negedge clk);
      exp_disp = 24'h000007;
      chk("ovl_result", {8'h0, data_to_display}, 32'h0000_0007);

      // CTRL write mid-conversion keeps it running; a hex write then aborts it.
      wr(BASE, 32'd555);
      repeat (4) @(negedge clk);
      wr(CTRL, 32'h0);
      chk("ctrl_noabort", {31'h0, busy}, 32'h1);
      chk("ctrl_nodisp", {8'h0, data_to_display}, {8'h0, exp_disp});
      hex_wr(32'h0012_3ABC);
      repeat (25) @(negedge clk);
      chk("abort_stays", {8'h0, data_to_display}, 32'h0012_3ABC);
      chk("abort_idle", {31'h0, busy}, 32'h0);

      // Reset on cycle 8 of a conversion.
      wr(CTRL, 32'h1);
      wr(BASE, 32'd314159);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_disp", {8'h0, data_to_display}, 32'h0);
      chk("rstmid_busy", {31'h0, busy}, 32'h0);
      chk("rstmid_mode", {31'h0, mode_dec}, 32'h0);
      exp_disp = 24'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("rstmid_after", {8'h0, data_to_display}, 32'h0);

      // Decode: near-miss addresses are ignored.
      hex_wr(32'h00AA_AAAA);
      wr(BASE + 32'd8, 32'h0055_5555);
      chk("dec_plus8", {8'h0, data_to_display}, 32'h00AA_AAAA);
      wr(BASE + 32'd1, 32'h0011_1111);
      chk("dec_plus1", {8'h0, data_to_display}, 32'h00AA_AAAA);
      wr(CTRL + 32'd4, 32'h1);
      chk("dec_ctrl_miss", {31'h0, mode_dec}, 32'h0);

      // Readback during a conversion.
      wr(CTRL, 32'h1);
      wr(BASE, 32'd10);
      addr = CTRL;
      #1;
`ifdef DISPLAY_READBACK_EN
      chk("rb_ctrl", rdata, 32'h3);
      addr = BASE;
      #1;
      chk("rb_data", rdata, {8'h0, exp_disp});
`else
      chk("rb_off", rdata, 32'h0);
`endif
      addr = 32'h0;
      repeat (25) @(negedge clk);
      exp_disp = 24'h000010;
      chk("rb_final", {8'h0, data_to_display}, 32'h0000_0010);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
